// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - Z80 bus FSM state type, default T-state constants and strobe decode helper
package z80_bus_pkg;

  localparam int TSTATE_CLKS_DEFAULT = 6;
  localparam int MAX_WAITS_DEFAULT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3,
    ST_DONE
  } z80_state_e;

  // The IORQ-qualified strobe is low from T2 through T3 inclusive.
  function automatic logic strobe_phase(input z80_state_e s);
    return (s == ST_T2) || (s == ST_TW) || (s == ST_T3);
  endfunction

endpackage

// File: rtl/tstate_timer.sv
// rtl/tstate_timer.sv - reloadable T-state down-counter with last-clock tick
module tstate_timer #(
  parameter int CLKS = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(CLKS);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS - 1);

  logic [CW-1:0] count;

  // Wraps to RELOAD on its own, so each T-state boundary needs no explicit reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en) begin
      count <= (count == '0) ? RELOAD : count - CW'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/z80_io_initiator.sv
// rtl/z80_io_initiator.sv - Z80 IN/OUT bus cycle initiator; define Z80_IO_WAIT_EN for wait_n/timeout support
module z80_io_initiator
  import z80_bus_pkg::*;
#(
  parameter int TSTATE_CLKS = TSTATE_CLKS_DEFAULT,
  parameter int MAX_WAITS   = MAX_WAITS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] A,
  output logic       rd_iorq_n,
  output logic       wr_iorq_n,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  input  logic [7:0] cd_in
`ifdef Z80_IO_WAIT_EN
  ,
  input  logic       wait_n,
  output logic       timeout
`endif
);

  z80_state_e state, state_next;
  logic       accept, tick, capture, strobe_on;
  logic       wr_q;
  logic [7:0] addr_q, wdata_q;

  tstate_timer #(.CLKS(TSTATE_CLKS)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (busy),
    .last  (tick)
  );

`ifdef Z80_IO_WAIT_EN
  localparam int WAIT_W = (MAX_WAITS < 1) ? 1 : $clog2(MAX_WAITS + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_max, timeout_set;

  assign wait_max = (wait_cnt == WAIT_W'(MAX_WAITS));

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      wait_cnt <= '0;
    end else if (state == ST_TW && tick && !wait_n && !wait_max) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
    timeout <= reset ? 1'b0 : timeout_set;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
`ifdef Z80_IO_WAIT_EN
    timeout_set = 1'b0;
`endif
    unique case (state)
      ST_IDLE: if (req) begin
        accept     = 1'b1;
        state_next = ST_T1;
      end
      ST_T1: if (tick) state_next = ST_T2;
      ST_T2: if (tick) state_next = ST_TW;
      ST_TW: if (tick) begin
`ifdef Z80_IO_WAIT_EN
        if (wait_n) begin
          state_next = ST_T3;
        end else if (wait_max) begin
          state_next  = ST_DONE;
          timeout_set = 1'b1;
        end
`else
        state_next = ST_T3;
`endif
      end
      ST_T3: if (tick) begin
        capture    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (capture && !wr_q) rdata <= cd_in;
    end
  end

  assign strobe_on = strobe_phase(state);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign rd_iorq_n = ~(strobe_on && !wr_q);
  assign wr_iorq_n = ~(strobe_on && wr_q);
  assign cd_oe     = busy && wr_q;
  assign A         = addr_q;
  assign cd_out    = wdata_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
// tb/tb_z80_io_initiator.sv - bench for z80_io_initiator; wait-state cases build with Z80_IO_WAIT_EN
module tb_z80_io_initiator;

  localparam int N    = 6;
  localparam int LAST = 4 * N + 1;

  logic       clk = 1'b0;
  logic       reset, req, wr;
  logic [7:0] addr, wdata, cd_in;
  logic       busy, done, rd_iorq_n, wr_iorq_n, cd_oe;
  logic [7:0] rdata, A, cd_out;
`ifdef Z80_IO_WAIT_EN
  logic       wait_n, timeout;
`endif

  int checks   = 0;
  int failures = 0;

  z80_io_initiator #(.TSTATE_CLKS(N), .MAX_WAITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .A         (A),
    .rd_iorq_n (rd_iorq_n),
    .wr_iorq_n (wr_iorq_n),
    .cd_out    (cd_out),
    .cd_oe     (cd_oe),
    .cd_in     (cd_in)
`ifdef Z80_IO_WAIT_EN
    ,
    .wait_n    (wait_n),
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected bus view c clocks after the accept edge, from the T-state timing rules.
  function automatic logic [20:0] model_out(input int c, input logic w,
                                            input logic [7:0] a, input logic [7:0] d);
    logic busy_e, done_e, low, oe_e;
    busy_e = (c >= 1) && (c <= LAST);
    done_e = (c == LAST);
    low    = (c >= N + 1) && (c <= 4 * N);
    oe_e   = w && busy_e;
    return {busy_e, done_e, ~(low && !w), ~(low && w), oe_e, a, oe_e ? d : 8'h00};
  endfunction

  task automatic run_cycle(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] ci, input logic [7:0] exp_rd, input bit poke);
    int dones;
    logic [20:0] got;
    dones = 0;
    wr = w; addr = a; wdata = d; cd_in = ci; req = 1'b1;
    for (int c = 1; c <= LAST + 1; c++) begin
      step();
      if (c == 1) begin
        wr = ~w; addr = ~a; wdata = ~d;
      end
      req = poke && (c == 10);
      got = {busy, done, rd_iorq_n, wr_iorq_n, cd_oe, A,
             (w && c <= LAST) ? cd_out : 8'h00};
      check($sformatf("cyc_a%0h_c%0d", a, c), got, model_out(c, w, a, d));
      if (done) dones++;
      if (c == LAST) check($sformatf("rdata_a%0h", a), rdata, exp_rd);
    end
    check($sformatf("done_count_a%0h", a), dones, 1);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a, d, ci, exp_rd;
    bit         poke;
  } vec_t;

  vec_t       vt[6];
  logic [7:0] last_rdata;
  logic       rw;
  logic [7:0] ra, rd, rc;
  bit         rp;
  int         nd, first, second, lows;

  initial begin
    vt[0] = '{1'b1, 8'h98, 8'h5A, 8'h00, 8'h00, 1'b0};
    vt[1] = '{1'b0, 8'h99, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vt[2] = '{1'b1, 8'h00, 8'hFF, 8'h3C, 8'hA5, 1'b1};
    vt[3] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[4] = '{1'b0, 8'h01, 8'h00, 8'h81, 8'h81, 1'b1};
    vt[5] = '{1'b1, 8'h7E, 8'h01, 8'hFF, 8'h81, 1'b0};

    reset = 1'b1; req = 1'b1; wr = 1'b1; addr = 8'h55; wdata = 8'hAA; cd_in = 8'h00;
`ifdef Z80_IO_WAIT_EN
    wait_n = 1'b1;
`endif
    repeat (3) step();
    check("reset_state", {busy, done, rd_iorq_n, wr_iorq_n, cd_oe, A, rdata, cd_out},
          {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
    reset = 1'b0; req = 1'b0;
    step();
    check("idle_after_reset", busy, 1'b0);

    for (int i = 0; i < 6; i++)
      run_cycle(vt[i].w, vt[i].a, vt[i].d, vt[i].ci, vt[i].exp_rd, vt[i].poke);
    last_rdata = 8'h81;

    for (int i = 0; i < 20; i++) begin
      rw = 1'($urandom); ra = 8'($urandom); rd = 8'($urandom);
      rc = 8'($urandom); rp = 1'($urandom);
      if (!rw) last_rdata = rc;
      run_cycle(rw, ra, rd, rc, last_rdata, rp);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        check("gap_idle", {busy, done}, 2'b00);
      end
    end

    // req held high: second cycle starts on the first IDLE clock
    wr = 1'b0; addr = 8'h42; cd_in = 8'h17; req = 1'b1;
    nd = 0; first = -1; second = -1;
    for (int c = 1; c <= 2 * LAST + 2; c++) begin
      step();
      if (done) begin
        nd++;
        if (nd == 1) first = c;
        else if (nd == 2) second = c;
      end
      if (c == LAST + 1) check("b2b_idle_clock", busy, 1'b0);
    end
    req = 1'b0;
    check("b2b_first_done", first, LAST);
    check("b2b_second_done", second, 2 * LAST + 1);
    check("b2b_done_count", nd, 2);
    check("b2b_rdata", rdata, 8'h17);

    // reset inside T2
    wr = 1'b1; addr = 8'h3C; wdata = 8'hC3; req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      req = 1'b0;
    end
    check("mid_strobe_low", wr_iorq_n, 1'b0);
    reset = 1'b1;
    step();
    check("mid_reset_state", {busy, done, rd_iorq_n, wr_iorq_n, cd_oe, A, rdata},
          {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done) nd++;
    end
    check("mid_no_done", nd, 0);

`ifdef Z80_IO_WAIT_EN
    wr = 1'b0; addr = 8'h10; cd_in = 8'h66; wait_n = 1'b0; req = 1'b1;
    nd = 0; first = -1; lows = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      req = 1'b0;
      if (c == 25) wait_n = 1'b1;
      if (!rd_iorq_n) lows++;
      if (done) begin
        nd++;
        if (first < 0) first = c;
      end
    end
    check("wait_done_clock", first, 37);
    check("wait_strobe_clocks", lows, 30);
    check("wait_done_count", nd, 1);
    check("wait_rdata", rdata, 8'h66);

    addr = 8'h11; cd_in = 8'h99; wait_n = 1'b0; req = 1'b1;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      req = 1'b0;
      if (done && first < 0) begin
        first = c;
        check("timeout_with_done", timeout, 1'b1);
      end
    end
    wait_n = 1'b1;
    check("timeout_done_clock", first, 37);
    check("timeout_rdata_kept", rdata, 8'h66);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
